// File: rtl/tdm_pkg.sv
// Shared constants and helpers for the TDM demultiplexer.
// State encodings, channel limit and index-width helper.
package tdm_pkg;

   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int TDM_MAX_CHANNELS = 16;

   function automatic int tdm_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer.
// Clear beats load-to-1, which beats increment; wraps after CHANNELS-1.
module tdm_slot_counter
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int IDX_W    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             load1,
   input  logic             clr,
   output logic [IDX_W-1:0] count,
   output logic             last
);

   logic [IDX_W-1:0] count_q;
   logic [IDX_W-1:0] count_d;

   assign last  = (count_q == IDX_W'(CHANNELS - 1));
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load1) begin
         count_d = IDX_W'(1);
      end else if (inc) begin
         count_d = last ? '0 : count_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: slot-interleaved stream in, coherent frame out.
// Optional even-parity checking enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 1,
   parameter int IDX_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          din,
   input  logic                      din_valid,
   input  logic                      frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
   input  logic                      din_par,
   output logic                      par_err,
`endif
   output logic [CHANNELS*WIDTH-1:0] dout,
   output logic                      dout_valid,
   output logic [IDX_W-1:0]          slot_idx,
   output logic                      locked,
   output logic                      sync_err
);

   localparam int SH_W = (CHANNELS - 1) * WIDTH;

   if (IDX_W != tdm_clog2(CHANNELS)) begin : g_bad_idx
      $error("IDX_W must equal clog2(CHANNELS)");
   end
   if (CHANNELS < 2 || CHANNELS > TDM_MAX_CHANNELS) begin : g_bad_ch
      $error("CHANNELS out of range");
   end

   logic [0:0]               state_q, state_d;
   logic [SH_W-1:0]          shadow_q, shadow_d;
   logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
   logic                     dv_q, dv_d;
   logic                     serr_q, serr_d;
   logic                     inc, load1, clr;
   logic [IDX_W-1:0]         count;
   logic                     last;

   tdm_slot_counter #(
      .CHANNELS (CHANNELS),
      .IDX_W    (IDX_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc),
      .load1 (load1),
      .clr   (clr),
      .count (count),
      .last  (last)
   );

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      dv_d     = 1'b0;
      serr_d   = 1'b0;
      inc      = 1'b0;
      load1    = 1'b0;
      clr      = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            ST_HUNT: begin
               if (frame_sync) begin
                  shadow_d[WIDTH-1:0] = din;
                  load1   = 1'b1;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               // A marker mid-frame restarts alignment on this sample
               if (frame_sync) begin
                  serr_d = (count != '0);
                  shadow_d[WIDTH-1:0] = din;
                  load1  = 1'b1;
               end else if (count == '0) begin
                  serr_d  = 1'b1;
                  clr     = 1'b1;
                  state_d = ST_HUNT;
               end else if (last) begin
                  dout_d = {din, shadow_q};
                  dv_d   = 1'b1;
                  inc    = 1'b1;
               end else begin
                  shadow_d[int'(count)*WIDTH +: WIDTH] = din;
                  inc = 1'b1;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HUNT;
         shadow_q <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         serr_q   <= serr_d;
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   logic perr_q, perr_d;
   logic par_err_q, par_err_d;
   logic samp_bad;

   assign samp_bad = ^{din, din_par};

   always_comb begin
      perr_d    = perr_q;
      par_err_d = 1'b0;
      if (load1) begin
         perr_d = samp_bad;
      end else if (dv_d) begin
         par_err_d = perr_q | samp_bad;
      end else if (inc) begin
         perr_d = perr_q | samp_bad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q    <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         perr_q    <= perr_d;
         par_err_q <= par_err_d;
      end
   end

   assign par_err = par_err_q;
`endif

   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign slot_idx   = count;
   assign locked     = (state_q == ST_RUN);
   assign sync_err   = serr_q;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a multiplexed link.
- Takes one shared serial-slot data stream carrying CHANNELS interleaved channels, with a frame marker on slot 0.
- Routes each slot's sample to its own registered output lane.
- Publishes a complete, coherent frame only after the last slot arrives. Sits downstream of the lab's 2:1/N:1 mux chains.

Parameters:
- CHANNELS, 4, number of time slots per frame (2..16).
- WIDTH, 1, bits per sample.
- IDX_W, 2, slot index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  sample for the current slot.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks slot 0.
- dout  output  CHANNELS*WIDTH  last complete frame; lane k at bits [k*WIDTH +: WIDTH].
- dout_valid  output  1  one-cycle pulse when dout updates.
- slot_idx  output  IDX_W  slot the next valid sample will fill.
- locked  output  1  FSM in RUN state.
- sync_err  output  1  one-cycle pulse on frame misalignment.

Behaviour:
- Reset (async assert, sync release): state=HUNT, slot counter=0, shadow regs=0, dout=0, dout_valid=0, slot_idx=0, locked=0, sync_err=0.
- HUNT state:
  - Samples with din_valid=1 and frame_sync=0 are ignored.
  - On din_valid=1 & frame_sync=1: store din in shadow[0], slot counter=1, go to RUN.
- RUN state, on din_valid=1:
  - frame_sync=0 and counter<CHANNELS-1: shadow[counter]<=din; counter++.
  - frame_sync=0 and counter==CHANNELS-1: dout<={din, shadow[CHANNELS-2:0]} (din into lane CHANNELS-1); dout_valid=1 next cycle; counter wraps to 0.
  - frame_sync=1 and counter==0: normal frame start; shadow[0]<=din; counter=1.
  - frame_sync=1 and counter!=0: misalignment. sync_err pulses, partial frame is discarded (dout unchanged, no dout_valid), din is taken as a new slot 0, counter=1, state stays RUN.
  - frame_sync=0 and counter==0: missing marker. sync_err pulses, sample is dropped, go to HUNT.
- din_valid=0: no state, counter or shadow change; gaps of any length are legal mid-frame.
- Latency: dout/dout_valid registered, 1 cycle after the clock edge capturing the last slot.
- dout holds its value between frames; it is never cleared except by reset.
- slot_idx = counter. locked = (state==RUN).
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- CHANNELS=2 must work (counter is 1 bit).

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Adds input din_par (1) and output par_err (1).
  - Each valid sample is checked against even parity over {din, din_par}.
  - A sticky per-frame mismatch flag is cleared at slot 0.
  - par_err is registered alongside dout_valid and is valid only when dout_valid=1.
  - A frame with a parity error still updates dout.
- Undefined: no din_par/par_err ports, no parity logic.

Decomposition:
- Shared package/include tdm_pkg:
  - state encodings HUNT=1'b0, RUN=1'b1.
  - constant for max CHANNELS.
  - clog2 function for IDX_W checks.
- One sub-module, tdm_slot_counter:
  - Ports: clk, rst_n, inc, load1, clr, count, last.
  - Performs wrap at CHANNELS-1 and load-to-1.
- The top level keeps the FSM, shadow registers and output register.

Test Plan:
- Reset then 4 valid samples 1,0,1,1 with frame_sync on the first -> one cycle later dout=4'b1101, dout_valid=1 for exactly 1 cycle, locked=1.
- Samples before any frame_sync (din_valid=1 ×5, frame_sync=0) -> locked=0, dout=0, no dout_valid.
- After lock, frame_sync at slot 2 -> sync_err 1-cycle pulse, no dout_valid for the broken frame; next 4 samples 0,1,1,0 -> dout=4'b0110.
- Missing frame_sync at slot 0 of the second frame -> sync_err pulse, locked=0; re-lock on the next marker and a correct frame follows.
- din_valid gaps of 0, 1 and 3 cycles between slots, plus rst_n pulled low at slot 2 -> gaps give the same dout as back-to-back; reset returns dout=0, slot_idx=0, locked=0 asynchronously.
- TDM_DEMUX_PARITY_EN defined, WIDTH=8: one slot sent with wrong din_par -> par_err=1 with that frame's dout_valid; next clean frame par_err=0.
